uart_tx_fifo: RTL and testbench

UART_TX_FIFO -- requirements
Module: uart_tx_fifo

---
 rtl/uart_tx_fifo.sv | 191 +++++++++++++++++++
 tb/tb_uart_tx_fifo.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_fifo.sv
// UART transmitter fed by a small word queue; frames are sent back to back while words remain.
// Define UART_TX_PARITY_EN to insert a parity bit (sense chosen by PAR_ODD) after the data bits.
module uart_tx_fifo #(
  parameter int DATA_W     = 8,
  parameter int BAUD_DIV   = 2604,
  parameter int STOP_BITS  = 1,
  parameter int FIFO_DEPTH = 4,
  parameter int PAR_ODD    = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              trmt,
  input  logic [DATA_W-1:0] tx_data,
  output logic              tx_full,
  output logic              tx_busy,
  output logic              tx_done,
  output logic              TX
);

  localparam int PTR_W  = $clog2(FIFO_DEPTH);
  localparam int CNT_W  = PTR_W + 1;
  localparam int BAUD_W = $clog2(BAUD_DIV);
  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(BAUD_DIV - 1);
  localparam logic [3:0]        DATA_LAST = 4'(DATA_W - 1);
  localparam logic [3:0]        STOP_LAST = 4'(STOP_BITS - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
`ifdef UART_TX_PARITY_EN
    PARITY,
`endif
    STOP
  } state_t;

  // ---------------------------------------------------------------- queue
  logic [DATA_W-1:0] mem [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr, rd_ptr;
  logic [CNT_W-1:0]  count;
  logic [DATA_W-1:0] head;
  logic              push, pop, queue_ne;

  assign tx_full  = (count == CNT_W'(FIFO_DEPTH));
  assign queue_ne = (count != '0);
  assign push     = trmt && !tx_full;
  assign head     = mem[rd_ptr];

  // NOTE: queue storage has no reset; the flushed pointers/count make stale words unreachable.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= tx_data;
  end

  // NOTE: all state updates use non-blocking assignment so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // ----------------------------------------------------------- frame FSM
  state_t            state, state_nxt;
  logic [BAUD_W-1:0] baud_cnt, baud_nxt;
  logic [3:0]        bit_idx, bit_nxt;
  logic [DATA_W-1:0] shreg, shreg_nxt;
  logic              tx_nxt;
  logic              baud_tc;

  assign baud_tc = (baud_cnt == BAUD_LAST);
  assign tx_busy = (state != IDLE);

`ifdef UART_TX_PARITY_EN
  localparam logic PAR_INIT = 1'(PAR_ODD);
  logic parity_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)   parity_q <= 1'b0;
    else if (pop) parity_q <= (^head) ^ PAR_INIT;
  end
`endif

  // NOTE: every output of this block gets a default first, so no path can infer a latch.
  always_comb begin
    state_nxt = state;
    baud_nxt  = baud_cnt;
    bit_nxt   = bit_idx;
    shreg_nxt = shreg;
    tx_nxt    = TX;
    pop       = 1'b0;

    if (state != IDLE) baud_nxt = baud_tc ? '0 : baud_cnt + 1'b1;

    case (state)
      IDLE: begin
        if (queue_ne) begin
          state_nxt = START;
          pop       = 1'b1;
          shreg_nxt = head;
          tx_nxt    = 1'b0;
          baud_nxt  = '0;
        end
      end
      START: begin
        if (baud_tc) begin
          state_nxt = DATA;
          bit_nxt   = '0;
          tx_nxt    = shreg[0];
        end
      end
      DATA: begin
        if (baud_tc) begin
          if (bit_idx == DATA_LAST) begin
`ifdef UART_TX_PARITY_EN
            state_nxt = PARITY;
            tx_nxt    = parity_q;
`else
            state_nxt = STOP;
            bit_nxt   = '0;
            tx_nxt    = 1'b1;
`endif
          end else begin
            bit_nxt   = bit_idx + 1'b1;
            shreg_nxt = shreg >> 1;
            tx_nxt    = shreg[1];
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      PARITY: begin
        if (baud_tc) begin
          state_nxt = STOP;
          bit_nxt   = '0;
          tx_nxt    = 1'b1;
        end
      end
`endif
      STOP: begin
        if (baud_tc) begin
          if (bit_idx != STOP_LAST) begin
            bit_nxt = bit_idx + 1'b1;
          end else if (queue_ne) begin
            // Chain straight into the next start bit so frames have no idle gap.
            state_nxt = START;
            pop       = 1'b1;
            shreg_nxt = head;
            tx_nxt    = 1'b0;
            baud_nxt  = '0;
          end else begin
            state_nxt = IDLE;
            tx_nxt    = 1'b1;
          end
        end
      end
      default: begin
        state_nxt = IDLE;
        tx_nxt    = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      baud_cnt <= '0;
      bit_idx  <= '0;
      shreg    <= '0;
      TX       <= 1'b1;
      tx_done  <= 1'b1;
    end else begin
      state    <= state_nxt;
      baud_cnt <= baud_nxt;
      bit_idx  <= bit_nxt;
      shreg    <= shreg_nxt;
      TX       <= tx_nxt;
      // A newly accepted word outranks a frame ending in the same cycle.
      if (push)                                      tx_done <= 1'b0;
      else if (state == STOP && state_nxt == IDLE)   tx_done <= 1'b1;
    end
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed bench for uart_tx_fifo: one 8N1 instance (A) and one 5-data/2-stop instance (B).
module tb_uart_tx_fifo;

  localparam int BAUD = 4;
`ifdef UART_TX_PARITY_EN
  localparam int PARB = 1;
`else
  localparam int PARB = 0;
`endif
  localparam int NS_A = 1 + 8 + PARB + 1;
  localparam int NS_B = 1 + 5 + PARB + 2;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       trmt_a = 1'b0, trmt_b = 1'b0;
  logic [7:0] data_a = '0;
  logic [4:0] data_b = '0;
  logic       full_a, busy_a, done_a, tx_a;
  logic       full_b, busy_b, done_b, tx_b;

  int tests_run = 0;
  int tests_failed = 0;

  logic mon_en = 1'b0;
  logic mon_sel = 1'b0;
  logic log_q[$];
  logic done_q[$];

  uart_tx_fifo #(.DATA_W(8), .BAUD_DIV(BAUD), .STOP_BITS(1), .FIFO_DEPTH(4), .PAR_ODD(0)) dut_a (
    .clk(clk), .rst_n(rst_n), .trmt(trmt_a), .tx_data(data_a),
    .tx_full(full_a), .tx_busy(busy_a), .tx_done(done_a), .TX(tx_a));

  uart_tx_fifo #(.DATA_W(5), .BAUD_DIV(BAUD), .STOP_BITS(2), .FIFO_DEPTH(4), .PAR_ODD(1)) dut_b (
    .clk(clk), .rst_n(rst_n), .trmt(trmt_b), .tx_data(data_b),
    .tx_full(full_b), .tx_busy(busy_b), .tx_done(done_b), .TX(tx_b));

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (mon_en) begin
      log_q.push_back(mon_sel ? tx_b : tx_a);
      done_q.push_back(mon_sel ? done_b : done_a);
    end
  end

  task automatic step(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic push_a(input logic [7:0] d);
    trmt_a = 1'b1; data_a = d; step(1); trmt_a = 1'b0;
  endtask

  task automatic push_b(input logic [4:0] d);
    trmt_b = 1'b1; data_b = d; step(1); trmt_b = 1'b0;
  endtask

  task automatic start_log(input logic sel);
    log_q.delete(); done_q.delete(); mon_sel = sel; mon_en = 1'b1;
  endtask

  function automatic logic sample(input int idx);
    if (idx < 0 || idx >= log_q.size()) return 1'bx;
    return log_q[idx];
  endfunction

  function automatic int find_start(input int from);
    for (int i = from; i < log_q.size(); i++) if (log_q[i] === 1'b0) return i;
    return -1;
  endfunction

  // Reads one frame out of the log; ok is cleared on any slot that is unstable or malformed.
  task automatic decode(input int idx, input int dw, input int nstop,
                        output logic [8:0] data, output logic par, output bit ok);
    int nslots;
    logic v;
    nslots = 1 + dw + PARB + nstop;
    ok = 1'b1; data = '0; par = 1'b0;
    if (idx < 0 || idx + nslots * BAUD > log_q.size()) begin ok = 1'b0; return; end
    for (int s = 0; s < nslots; s++) begin
      v = sample(idx + s * BAUD);
      for (int k = 1; k < BAUD; k++) if (sample(idx + s * BAUD + k) !== v) ok = 1'b0;
      if (s == 0 && v !== 1'b0) ok = 1'b0;
      if (s >= 1 && s <= dw) data[s-1] = v;
      if (PARB == 1 && s == dw + 1) par = v;
      if (s > dw + PARB && v !== 1'b1) ok = 1'b0;
    end
  endtask

  task automatic wait_idle(input logic sel, input int bound);
    bit seen = 1'b0;
    for (int i = 0; i < bound && !seen; i++) begin
      step(1);
      if (sel ? (done_b && !busy_b) : (done_a && !busy_a)) seen = 1'b1;
    end
    tests_run++;
    if (!seen) begin tests_failed++; $display("FAIL wait_idle: got busy, required idle within %0d cycles", bound); end
  endtask

  task automatic wait_start_a(input int bound);
    bit seen = 1'b0;
    for (int i = 0; i < bound && !seen; i++) begin
      if (tx_a === 1'b0) seen = 1'b1;
      else step(1);
    end
    tests_run++;
    if (!seen) begin tests_failed++; $display("FAIL wait_start: no start bit within %0d cycles", bound); end
  endtask

  task automatic test_reset;
    #12;
    tests_run++; if (tx_a !== 1'b1)   begin tests_failed++; $display("FAIL reset_tx_a: got %b required 1", tx_a); end
    tests_run++; if (busy_a !== 1'b0) begin tests_failed++; $display("FAIL reset_busy_a: got %b required 0", busy_a); end
    tests_run++; if (full_a !== 1'b0) begin tests_failed++; $display("FAIL reset_full_a: got %b required 0", full_a); end
    tests_run++; if (done_a !== 1'b1) begin tests_failed++; $display("FAIL reset_done_a: got %b required 1", done_a); end
    tests_run++; if (tx_b !== 1'b1)   begin tests_failed++; $display("FAIL reset_tx_b: got %b required 1", tx_b); end
    tests_run++; if (done_b !== 1'b1) begin tests_failed++; $display("FAIL reset_done_b: got %b required 1", done_b); end
    @(negedge clk); rst_n = 1'b1;
    step(2);
  endtask

  task automatic test_single_frame;
    logic [8:0] d; logic p; bit ok; int i0;
    start_log(1'b0);
    push_a(8'hA5);
    tests_run++; if (tx_a !== 1'b1)   begin tests_failed++; $display("FAIL latency_early: got TX=%b required 1", tx_a); end
    tests_run++; if (done_a !== 1'b0) begin tests_failed++; $display("FAIL done_clear: got %b required 0", done_a); end
    step(1);
    tests_run++; if (tx_a !== 1'b0)   begin tests_failed++; $display("FAIL latency_start: got TX=%b required 0", tx_a); end
    tests_run++; if (busy_a !== 1'b1) begin tests_failed++; $display("FAIL busy_in_frame: got %b required 1", busy_a); end
    wait_idle(1'b0, 80);
    step(4); mon_en = 1'b0;
    i0 = find_start(0);
    decode(i0, 8, 1, d, p, ok);
    tests_run++; if (!ok)           begin tests_failed++; $display("FAIL a5_shape: got malformed frame at %0d, required clean 8N1", i0); end
    tests_run++; if (d !== 9'h0A5)  begin tests_failed++; $display("FAIL a5_data: got %h required 0a5", d); end
`ifdef UART_TX_PARITY_EN
    tests_run++; if (p !== 1'b0)    begin tests_failed++; $display("FAIL a5_parity: got %b required 0", p); end
`endif
    tests_run++; if (sample(i0 + NS_A * BAUD) !== 1'b1) begin tests_failed++; $display("FAIL a5_length: got %b after frame required 1", sample(i0 + NS_A * BAUD)); end
    tests_run++; if (done_a !== 1'b1) begin tests_failed++; $display("FAIL done_set: got %b required 1", done_a); end
    tests_run++; if (busy_a !== 1'b0) begin tests_failed++; $display("FAIL busy_idle: got %b required 0", busy_a); end
  endtask

`ifdef UART_TX_PARITY_EN
  task automatic test_parity;
    logic [8:0] d; logic p; bit ok;
    start_log(1'b0); push_a(8'h07); wait_idle(1'b0, 80); step(2); mon_en = 1'b0;
    decode(find_start(0), 8, 1, d, p, ok);
    tests_run++; if (!ok || p !== 1'b1) begin tests_failed++; $display("FAIL parity_even: got ok=%b par=%b required ok=1 par=1", ok, p); end
    start_log(1'b1); push_b(5'h07); wait_idle(1'b1, 80); step(2); mon_en = 1'b0;
    decode(find_start(0), 5, 2, d, p, ok);
    tests_run++; if (!ok || p !== 1'b0) begin tests_failed++; $display("FAIL parity_odd: got ok=%b par=%b required ok=1 par=0", ok, p); end
  endtask
`endif

  task automatic test_fifo_full;
    logic [7:0] words [6] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
    logic [8:0] d; logic p; bit ok; int i0;
    start_log(1'b0);
    trmt_a = 1'b1;
    for (int i = 0; i < 6; i++) begin
      data_a = words[i];
      if (i == 4) begin
        tests_run++; if (full_a !== 1'b0) begin tests_failed++; $display("FAIL full_early: got %b required 0", full_a); end
      end
      if (i == 5) begin
        tests_run++; if (full_a !== 1'b1) begin tests_failed++; $display("FAIL full_set: got %b required 1", full_a); end
      end
      step(1);
    end
    trmt_a = 1'b0;
    wait_idle(1'b0, 300);
    step(20); mon_en = 1'b0;
    i0 = find_start(0);
    for (int f = 0; f < 5; f++) begin
      decode(i0 + f * NS_A * BAUD, 8, 1, d, p, ok);
      tests_run++;
      if (!ok || d !== {1'b0, words[f]}) begin
        tests_failed++; $display("FAIL burst_frame%0d: got ok=%b data=%h required ok=1 data=%h", f, ok, d, words[f]);
      end
    end
    tests_run++;
    if (find_start(i0 + 5 * NS_A * BAUD) != -1) begin tests_failed++; $display("FAIL burst_drop: got a 6th frame, required none"); end
  endtask

  task automatic test_stop2;
    logic [8:0] d; logic p; bit ok; int zeros;
    start_log(1'b1);
    push_b(5'h1F);
    wait_idle(1'b1, 80);
    step(5); mon_en = 1'b0;
    decode(find_start(0), 5, 2, d, p, ok);
    tests_run++; if (!ok || d !== 9'h01F) begin tests_failed++; $display("FAIL stop2_frame: got ok=%b data=%h required ok=1 data=01f", ok, d); end
    zeros = 0;
    foreach (log_q[i]) if (log_q[i] === 1'b0) zeros++;
    tests_run++; if (zeros != BAUD + PARB * BAUD) begin tests_failed++; $display("FAIL stop2_low: got %0d low clocks required %0d", zeros, BAUD + PARB * BAUD); end
  endtask

  task automatic test_reset_mid_frame;
    bit all_high;
    push_a(8'hA5);
    push_a(8'h3C);
    wait_start_a(10);
    step(17);
    tests_run++; if (tx_a !== 1'b0) begin tests_failed++; $display("FAIL mid_bit3: got %b required 0", tx_a); end
    rst_n = 1'b0; #1;
    tests_run++; if (tx_a !== 1'b1)   begin tests_failed++; $display("FAIL abort_tx: got %b required 1", tx_a); end
    tests_run++; if (busy_a !== 1'b0) begin tests_failed++; $display("FAIL abort_busy: got %b required 0", busy_a); end
    tests_run++; if (done_a !== 1'b1) begin tests_failed++; $display("FAIL abort_done: got %b required 1", done_a); end
    @(negedge clk); rst_n = 1'b1;
    step(1);
    start_log(1'b0); step(80); mon_en = 1'b0;
    all_high = 1'b1;
    foreach (log_q[i]) if (log_q[i] !== 1'b1) all_high = 1'b0;
    tests_run++; if (!all_high) begin tests_failed++; $display("FAIL abort_flush: got activity after reset, required idle line"); end
  endtask

  task automatic test_back_to_back;
    logic [8:0] d; logic p; bit ok; int i0; bit done_low;
    start_log(1'b0);
    push_a(8'h5A);
    wait_start_a(10);
    step((1 + 8 + PARB) * BAUD + 1);
    push_a(8'hC3);
    wait_idle(1'b0, 120);
    step(4); mon_en = 1'b0;
    i0 = find_start(0);
    decode(i0, 8, 1, d, p, ok);
    tests_run++; if (!ok || d !== 9'h05A) begin tests_failed++; $display("FAIL b2b_first: got ok=%b data=%h required ok=1 data=05a", ok, d); end
    decode(i0 + NS_A * BAUD, 8, 1, d, p, ok);
    tests_run++; if (!ok || d !== 9'h0C3) begin tests_failed++; $display("FAIL b2b_second: got ok=%b data=%h required ok=1 data=0c3", ok, d); end
    done_low = (i0 >= 0);
    for (int i = i0; i >= 0 && i < i0 + 2 * NS_A * BAUD && i < done_q.size(); i++) if (done_q[i] !== 1'b0) done_low = 1'b0;
    tests_run++; if (!done_low) begin tests_failed++; $display("FAIL b2b_done: got tx_done high between frames, required low"); end
  endtask

  initial begin
    test_reset();
    test_single_frame();
`ifdef UART_TX_PARITY_EN
    test_parity();
`endif
    test_fifo_full();
    test_stop2();
    test_reset_mid_frame();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
